fir_stream_feeder: RTL and testbench
====================================

# fir_stream_feeder

Drives the sample-input side of the 64-tap sequential-MAC FIR core and collects its filtered output. Upstream samples arrive on a valid/ready stream, are buffered in a small FIFO, and are issued to the core as one 64-cycle `ready` burst per sample. The core result is captured and presented downstream on a valid/ready stream with backpressure. The block sits between the sample source (ADC/deserialiser) and the FIR core, and owns all core pacing.

## Interface
- `WIDTH`, 18: sample and result width, signed two's complement.
- `FRAME_LEN`, 64: `ready` cycles per core frame. Must equal the core tap count.
- `FIFO_DEPTH`, 4: input FIFO entries. Power of two, at least 2.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_data`  in  WIDTH  upstream sample.
- `s_valid`  in  1  upstream sample valid.
- `s_ready`  out  1  FIFO not full; transfer occurs when `s_valid && s_ready`.
- `core_sample`  out  WIDTH  sample to core `input_sig`; registered.
- `core_ready`  out  1  to core `ready`; registered.
- `core_result`  in  WIDTH  from core `filtred_sig`.
- `m_data`  out  WIDTH  filtered sample.
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  downstream accept.
- `busy`  out  1  burst in progress or FIFO non-empty.

## Operation
- Core contract:
  - The core advances its tap counter only on `core_ready` cycles.
  - It latches `input_sig` and updates `filtred_sig` at the end of the first `ready` cycle of each frame.
  - The value it produces at that edge is the result of the previous frame.
- FIFO:
  - Write on `s_valid && s_ready`. `s_ready = (count != FIFO_DEPTH)`, combinational from the registered count.
  - Simultaneous push and pop when full is not permitted, because `s_ready` is low when full.
  - Push and pop in the same cycle at intermediate levels leaves the count unchanged.
- States:
  - IDLE: `core_ready`=0. Leave when `start` is true.
  - BURST: `core_ready`=1. Frame counter `cnt` runs 0..FRAME_LEN-1.
- `start` = FIFO non-empty AND (`m_valid`==0 OR `m_ready`==1).
- At the edge entering `cnt`=0, whether from IDLE or from `cnt`=FRAME_LEN-1:
  - pop the FIFO head into `core_sample`;
  - set `core_ready`=1.
- At `cnt`=1:
  - load `core_result` into `m_data`;
  - set `m_valid`=1 if `primed`, else leave `m_valid` unchanged;
  - set `primed`=1.
  - The first burst after reset produces no output.
- At `cnt`=FRAME_LEN-1:
  - if `start`, wrap to `cnt`=0 with the next sample, so `core_ready` stays high with no gap;
  - else go to IDLE, so `core_ready`=0 next cycle.
- `m_valid` clears on `m_valid && m_ready`, unless reloaded in the same cycle.
- Because of `start`, at most one undelivered result exists. The result of sample n is delivered during the burst of sample n+1. A trailing result stays in the core until the next sample arrives.
- `core_ready` falls only at frame boundaries, never mid-frame.
- Arithmetic: none. Data passes bit-exact. No sign extension or truncation.

## Timing
- Reset values:
  - `core_ready`=0, `core_sample`=0, `m_data`=0, `m_valid`=0, `busy`=0;
  - FIFO empty, so `s_ready`=1; `primed`=0; state IDLE; `cnt`=0.
- Latency from idle, with a sample accepted at edge t:
  - `core_ready` rises after edge t+1;
  - `core_sample` is valid at that same point.
- Result latency: `m_valid` rises 2 cycles after the start of the next burst.
- Throughput: one sample per FRAME_LEN cycles when fed continuously.
- Reset mid-burst:
  - the block returns to IDLE and drops `core_ready` immediately (asynchronous);
  - `primed` clears and the FIFO empties.
  - The system resets the core in the same event. The block does not resynchronise the core counter.

## Test plan
All tests use a stub core that registers `core_sample + 1000` onto `core_result` on the first `ready` cycle of each frame, and checks that `ready` is asserted only in full 64-cycle runs.
- Single sample 5 after reset: `core_ready` high for exactly 64 cycles, then low; `m_valid` stays 0.
- Samples 5 then 7:
  - two back-to-back bursts with no `core_ready` gap;
  - `m_data`=1005 with `m_valid` rising at `cnt`=1 of the second burst.
- Burst of 6 samples with `s_valid` held high:
  - `s_ready` drops after 4 are buffered;
  - all 6 are issued in order;
  - outputs 1st..5th equal sample+1000.
- `m_ready`=0 held:
  - after the first output, no new burst starts;
  - `core_ready` stays 0 at the frame end;
  - raising `m_ready` releases the stall and the next burst starts on the following cycle.
- `rst_n` pulsed at `cnt`=30: `core_ready`, `m_valid`, `busy`=0 immediately; FIFO empty; the next sample gives no output on its first burst.
- Simultaneous `m_ready` handshake and reload at `cnt`=1: `m_valid` stays 1 and `m_data` takes the new value, with no lost or duplicated output.

Source files
------------

// File: rtl/fir_stream_feeder.sv
// fir_stream_feeder: buffers upstream samples in a small FIFO and issues each
// one to the sequential-MAC FIR core as a FRAME_LEN-cycle ready burst. The core
// result is captured early in the next burst and offered downstream on a
// valid/ready stream with backpressure.
module fir_stream_feeder #(
  parameter int WIDTH      = 18,
  parameter int FRAME_LEN  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] core_sample,
  output logic             core_ready,
  input  logic [WIDTH-1:0] core_result,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(FRAME_LEN);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] count_q;

  logic primed_q;
  logic push, pop, start, last, load_result;

  assign s_ready = (count_q != FULL_LVL);
  assign push    = s_valid && s_ready;
  // A new burst may only begin once the previous result has a free slot to land in.
  assign start   = (count_q != '0) && (!m_valid || m_ready);
  assign last    = (cnt_q == LAST_CNT);
  // The core has updated its result by the second cycle of a frame.
  assign load_result = (state_q == BURST) && (cnt_q == LOAD_CNT);
  assign busy    = (state_q == BURST) || (count_q != '0);

  // Next-state logic: start, continue, wrap or end a burst, and decide on a pop.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BURST;
          cnt_d   = '0;
          pop     = 1'b1;
        end
      end
      BURST: begin
        if (last) begin
          cnt_d = '0;
          if (start) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State register; core_ready is registered so it follows the burst state with no glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      core_ready <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      core_ready <= (state_d == BURST);
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array carries no reset; an entry is only read after the count says it was written.
    if (push) begin
      fifo_mem[wr_ptr_q] <= s_data;
    end
  end

  // FIFO pointers and fill level; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + LVL_W'(1);
        2'b01:   count_q <= count_q - LVL_W'(1);
        default: ;
      endcase
    end
  end

  // Present the FIFO head to the core at the start of each frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_sample <= '0;
    end else if (pop) begin
      core_sample <= fifo_mem[rd_ptr_q];
    end
  end

  // Downstream output register; the first burst after reset only primes the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data   <= '0;
      m_valid  <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (load_result) begin
        m_data   <= core_result;
        primed_q <= 1'b1;
        if (primed_q) begin
          m_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_feeder.sv
// tb_fir_stream_feeder: directed and randomized checks of the FIR stream feeder
// against a stub core and an in-order sample/result reference model.
module tb_fir_stream_feeder;

  localparam int WIDTH     = 18;
  localparam int FRAME_LEN = 64;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] core_sample;
  logic             core_ready;
  logic [WIDTH-1:0] core_result;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             busy;

  fir_stream_feeder #(
    .WIDTH      (WIDTH),
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .core_sample (core_sample),
    .core_ready  (core_ready),
    .core_result (core_result),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Stub core: on the first ready cycle of a frame it latches the new sample
  // and publishes the previous sample + 1000, like the real core's one-frame lag.
  int               stub_cnt;
  logic [WIDTH-1:0] core_held;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cnt    <= 0;
      core_held   <= '0;
      core_result <= '0;
    end else if (core_ready) begin
      if (stub_cnt == 0) begin
        core_result <= core_held + WIDTH'(1000);
        core_held   <= core_sample;
      end
      stub_cnt <= (stub_cnt == FRAME_LEN - 1) ? 0 : stub_cnt + 1;
    end
  end

  // Reference model: accepted samples in order; the k-th issue must be the
  // k-th accepted sample and the k-th output must be that sample + 1000.
  logic [WIDTH-1:0] acc_q[$];
  int               issue_idx;
  int               out_idx;
  int               run_len;
  bit               hold_q;
  logic [WIDTH-1:0] hold_data;
  logic [WIDTH-1:0] exp_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      issue_idx = 0;
      out_idx   = 0;
      run_len   = 0;
      hold_q    = 1'b0;
    end else begin
      if (s_valid && s_ready) acc_q.push_back(s_data);
      if (core_ready && stub_cnt == 0) begin
        check("issue_exists", issue_idx < acc_q.size(), 1);
        if (issue_idx < acc_q.size()) check("issue_order", core_sample, acc_q[issue_idx]);
        issue_idx++;
      end
      if (core_ready) begin
        run_len++;
      end else if (run_len != 0) begin
        check("ready_run_whole_frames", run_len % FRAME_LEN, 0);
        run_len = 0;
      end
      if (hold_q) begin
        check("stall_valid_held", m_valid, 1);
        check("stall_data_held", m_data, hold_data);
      end
      if (m_valid && m_ready) begin
        check("out_has_successor", out_idx + 1 < issue_idx, 1);
        if (out_idx < acc_q.size()) begin
          exp_d = acc_q[out_idx] + WIDTH'(1000);
          check("out_data", m_data, exp_d);
        end
        out_idx++;
      end
      hold_q    = m_valid && !m_ready;
      hold_data = m_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    int t;
    t = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && t < 500) begin
      step();
      t++;
    end
    check("send_timeout", t < 500, 1);
    step();
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int t;
    t = 0;
    while ((busy || m_valid || core_ready) && t < limit) begin
      step();
      t++;
    end
    check("idle_timeout", t < limit, 1);
  endtask

  task automatic check_drained();
    check("drain_issued", issue_idx, acc_q.size());
    check("drain_outputs", out_idx, acc_q.size() - 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int               n, mv, hi, fall_k, mv_k, sent;
    logic [WIDTH-1:0] mv_d, va, vb, vc;
    bit               xfer;

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst_core_ready", core_ready, 0);
    check("rst_core_sample", core_sample, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 1);
    rst_n = 1'b1;
    step();
    check("post_rst_busy", busy, 0);

    // Single sample: one 64-cycle burst, no output
    send(WIDTH'(5));
    check("t1_ready_before", core_ready, 0);
    check("t1_busy", busy, 1);
    step();
    check("t1_ready_rise", core_ready, 1);
    check("t1_sample", core_sample, 5);
    n  = 0;
    mv = 0;
    while (core_ready && n < 200) begin
      n++;
      if (m_valid) mv++;
      step();
    end
    check("t1_ready_len", n, 64);
    check("t1_no_output", mv, 0);
    repeat (5) step();
    check("t1_still_no_output", m_valid, 0);
    check_drained();

    // Samples 5 then 7: back-to-back bursts, result 1005 two cycles into burst 2
    do_reset();
    send(WIDTH'(5));
    send(WIDTH'(7));
    hi     = 0;
    fall_k = -1;
    mv_k   = -1;
    mv_d   = '0;
    for (int k = 0; k < 140; k++) begin
      if (core_ready) hi++;
      else if (fall_k < 0) fall_k = k;
      if (m_valid && mv_k < 0) begin
        mv_k = k;
        mv_d = m_data;
      end
      step();
    end
    check("t2_ready_cycles", hi, 128);
    check("t2_ready_fall", fall_k, 128);
    check("t2_mvalid_rise", mv_k, 66);
    check("t2_mdata", mv_d, 1005);
    wait_idle(200);
    check_drained();

    // Six random samples with s_valid held: FIFO fills, all issued in order
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(WIDTH'($urandom));
      s_valid = 1'b1;
      if (i == 3) check("t3_room_after_4", s_ready, 1);
      if (i == 4) check("t3_full_after_5", s_ready, 0);
    end
    s_valid = 1'b0;
    wait_idle(1000);
    check_drained();

    // Downstream stall: no new burst while a result waits, release resumes next cycle
    do_reset();
    m_ready = 1'b0;
    va = WIDTH'($urandom);
    vb = WIDTH'($urandom);
    vc = WIDTH'($urandom);
    send(va);
    send(vb);
    send(vc);
    repeat (127) step();
    check("t4_stalled_ready", core_ready, 0);
    check("t4_stalled_valid", m_valid, 1);
    exp_d = va + WIDTH'(1000);
    check("t4_stalled_data", m_data, exp_d);
    check("t4_stalled_busy", busy, 1);
    repeat (10) step();
    check("t4_still_stalled", core_ready, 0);
    m_ready = 1'b1;
    step();
    check("t4_release_ready", core_ready, 1);
    check("t4_release_sample", core_sample, vc);
    wait_idle(200);
    check_drained();

    // Reset at cnt=30 of a stalled second burst, then a fresh first burst gives no output
    do_reset();
    m_ready = 1'b0;
    send(WIDTH'($urandom));
    send(WIDTH'($urandom));
    send(WIDTH'($urandom));
    repeat (93) step();
    check("t5_pre_ready", core_ready, 1);
    check("t5_pre_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ready", core_ready, 0);
    check("t5_rst_valid", m_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_s_ready", s_ready, 1);
    check("t5_rst_sample", core_sample, 0);
    step();
    step();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    send(WIDTH'($urandom));
    step();
    hi = 0;
    mv = 0;
    for (int k = 0; k < 70; k++) begin
      if (core_ready) hi++;
      if (m_valid) mv++;
      step();
    end
    check("t5_first_burst_len", hi, 64);
    check("t5_first_burst_quiet", mv, 0);
    check_drained();

    // Randomized traffic with random backpressure against the model
    do_reset();
    sent = 0;
    for (int c = 0; c < 2500; c++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if (!s_valid && sent < 16 && $urandom_range(0, 29) == 0) begin
        s_data  = WIDTH'($urandom);
        s_valid = 1'b1;
      end
      xfer = s_valid && s_ready;
      step();
      if (xfer) begin
        s_valid = 1'b0;
        sent++;
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    wait_idle(2000);
    check("rand_some_traffic", sent > 2, 1);
    check_drained();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
